// File: rtl/cnt_pkg.sv
// Shared types and constants for the up/down modulo counter.
// Provides the run-time mode encoding and the direction literals.
package cnt_pkg;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_t;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated clock-enable divider: tick on every PRESCALE-th enabled cycle.
// Only instantiated when CNT_PRESCALE_EN is defined.
module tick_divider #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] div_p1;

  assign tick = en && (div_p1 == LAST);

  // ---- stage p1: divider phase register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_p1 <= '0;
    end else if (clr) begin
      div_p1 <= '0;
    end else if (en) begin
      div_p1 <= tick ? '0 : div_p1 + CW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable terminal value, saturate/wrap mode and load.
// Optional prescaled stepping is built when CNT_PRESCALE_EN is defined.
module updown_mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  mode_t            mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] val_out,
  output logic             at_max,
  output logic             at_min,
  output logic             bnd_evt
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if (MAX_VAL < 0 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
    $error("updown_mod_counter: MAX_VAL out of range for WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_mod_counter: PRESCALE must be >= 1");
  end

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_W) ? MAX_W : v;
  endfunction

  // Returns {bound_hit, next_value}; bounds are tested before any +/-1.
  function automatic logic [WIDTH:0] step_val(input logic [WIDTH-1:0] v,
                                              input logic dir, input mode_t md);
    logic [WIDTH:0] r;
    r = {1'b0, v};
    case (dir)
      UP: r = (v == MAX_W) ? {1'b1, (md == MODE_WRAP) ? '0 : MAX_W}
                           : {1'b0, v + WIDTH'(1)};
      DN: r = (v == '0)    ? {1'b1, (md == MODE_WRAP) ? MAX_W : '0}
                           : {1'b0, v - WIDTH'(1)};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  logic step_tick;

`ifdef CNT_PRESCALE_EN
  tick_divider #(.PRESCALE(PRESCALE)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (en),
    .tick  (step_tick)
  );
`else
  assign step_tick = 1'b1;
`endif

  logic [WIDTH-1:0] cnt_p0, cnt_p1;
  logic             evt_p0, evt_p1;

  // ---- stage p0: next-state selection (load > step > hold) ----
  always_comb begin
    cnt_p0 = cnt_p1;
    evt_p0 = 1'b0;
    if (load) begin
      cnt_p0 = clamp_load(load_val);
    end else if (en && step_tick) begin
      {evt_p0, cnt_p0} = step_val(cnt_p1, up_dn, mode);
    end
  end

  // ---- stage p1: count and bound-event registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1 <= '0;
      evt_p1 <= 1'b0;
    end else begin
      cnt_p1 <= cnt_p0;
      evt_p1 <= evt_p0;
    end
  end

  assign val_out = cnt_p1;
  assign bnd_evt = evt_p1;
  assign at_max  = (cnt_p1 == MAX_W);
  assign at_min  = (cnt_p1 == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: full-range (MAX 15) and clamped (MAX 12) instances.
module tb_updown_mod_counter;
  import cnt_pkg::*;

`ifdef CNT_PRESCALE_EN
  localparam int TB_PS = 3;
`else
  localparam int TB_PS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up_dn = 1'b1, load = 1'b0;
  mode_t      mode = MODE_SAT;
  logic [3:0] load_val = 4'd0;

  logic [3:0] val_a, val_b;
  logic       amax_a, amin_a, evt_a, amax_b, amin_b, evt_b;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(TB_PS)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .val_out(val_a), .at_max(amax_a), .at_min(amin_a), .bnd_evt(evt_a));

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(12), .PRESCALE(TB_PS)) dut12 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .val_out(val_b), .at_max(amax_b), .at_min(amin_b), .bnd_evt(evt_b));

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: plain integers, no register encoding.
  int m15 = 0, m12 = 0, div = 0;
  bit e15 = 0, e12 = 0;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got val=%0d max=%b min=%b evt=%b, want val=%0d max=%b min=%b evt=%b",
               name, act[6:3], act[2], act[1], act[0], req[6:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic ref_step(input int mx, input bit u, input bit w, inout int m, inout bit ev);
    int n;
    n  = u ? m + 1 : m - 1;
    ev = (n > mx) || (n < 0);
    if (n > mx) n = w ? 0 : mx;
    if (n < 0)  n = w ? mx : 0;
    m = n;
  endtask

  function automatic logic [6:0] flags(input int m, input int mx, input bit ev);
    return {4'(m), m == mx, m == 0, ev};
  endfunction

  task automatic cycle(input bit r, input bit e, input bit u, input mode_t md,
                       input bit ld, input int lv);
    bit tick;
    @(negedge clk);
    reset = r; en = e; up_dn = u; mode = md; load = ld; load_val = 4'(lv);
    if (r) begin
      m15 = 0; m12 = 0; e15 = 0; e12 = 0; div = 0;
    end else if (ld) begin
      m15 = lv; m12 = (lv > 12) ? 12 : lv; e15 = 0; e12 = 0; div = 0;
    end else begin
      tick = 0;
      if (e) begin
        div++;
        if (div == TB_PS) begin tick = 1; div = 0; end
      end
      if (tick) begin
        ref_step(15, u, md == MODE_WRAP, m15, e15);
        ref_step(12, u, md == MODE_WRAP, m12, e12);
      end else begin
        e15 = 0; e12 = 0;
      end
    end
    exp_q.push_back('{a: flags(m15, 15, e15), b: flags(m12, 12, e12)});
  endtask

  // Monitor: one registered result per posedge, checked against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("cnt15", {val_a, amax_a, amin_a, evt_a}, got.a);
        chk("cnt12", {val_b, amax_b, amin_b, evt_b}, got.b);
      end
    end
  end

  initial begin
    int wait_cyc;
    #1;
    chk("reset15", {val_a, amax_a, amin_a, evt_a}, 7'b0000_0_1_0);
    chk("reset12", {val_b, amax_b, amin_b, evt_b}, 7'b0000_0_1_0);

    // Async reset after counting up.
    cycle(1, 0, UP, MODE_SAT, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, UP, MODE_SAT, 0, 0);
    cycle(1, 1, UP, MODE_SAT, 0, 0);
    #1;
    chk("async15", {val_a, amax_a, amin_a, evt_a}, 7'b0000_0_1_0);
    chk("async12", {val_b, amax_b, amin_b, evt_b}, 7'b0000_0_1_0);
    cycle(1, 1, UP, MODE_SAT, 1, 9);

    // Saturating up-count past the bound.
    for (int i = 0; i < 20 * TB_PS; i++) cycle(0, 1, UP, MODE_SAT, 0, 0);

    // Wrap up then down around the bounds.
    cycle(0, 0, UP, MODE_WRAP, 1, 14);
    for (int i = 0; i < 3 * TB_PS; i++) cycle(0, 1, UP, MODE_WRAP, 0, 0);
    for (int i = 0; i < 3 * TB_PS; i++) cycle(0, 1, DN, MODE_WRAP, 0, 0);

    // Load beats step; clamping on the MAX 12 instance.
    cycle(0, 1, UP, MODE_WRAP, 1, 9);
    cycle(0, 1, DN, MODE_SAT, 1, 14);
    cycle(0, 0, DN, MODE_SAT, 1, 15);

    // Hold with en low while mode/direction toggle.
    cycle(0, 0, UP, MODE_SAT, 1, 6);
    for (int i = 0; i < 5; i++) cycle(0, 0, i[0], mode_t'(i[1]), 0, 0);

    // Down-saturation at zero.
    cycle(0, 0, DN, MODE_SAT, 1, 1);
    for (int i = 0; i < 4 * TB_PS; i++) cycle(0, 1, DN, MODE_SAT, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            mode_t'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 15));
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
